// File: rtl/fifo2core_unpack_pkg.sv
// Shared constants for the weight FIFO unpacker: layer codes, per-layer word counts,
// FSM state encoding and a layer-classification helper.
package fifo2core_unpack_pkg;

    localparam int WCNT_W = 6;

    // Words per weight layer; the BRAM->FIFO controller uses the same counts.
    localparam int N_C1_DEF = 2;
    localparam int N_C3_DEF = 4;
    localparam int N_C5_DEF = 24;
    localparam int N_FC_DEF = 17;
    localparam int N_OL_DEF = 2;

    typedef enum logic [2:0] {
        L_IDLE = 3'b000,
        L_C1   = 3'b001,
        L_S2   = 3'b010,
        L_C3   = 3'b011,
        L_S4   = 3'b100,
        L_C5   = 3'b101,
        L_FC   = 3'b110,
        L_OL   = 3'b111
    } layer_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_RDWAIT,
        ST_EMIT,
        ST_DONE
    } state_e;

    // Pooling layers (S2, S4) carry no weights and never start a run.
    function automatic logic is_weight_layer(input logic [2:0] code);
        return (code == L_C1) || (code == L_C3) || (code == L_C5) ||
               (code == L_FC) || (code == L_OL);
    endfunction

endpackage

// File: rtl/fifo2core_unpack_if.sv
// Bundle of FIFO-side and core-side signals of the weight unpacker.
// master = unpacker side, slave = FIFO/core/controller side.
interface fifo2core_unpack_if #(
    parameter int MEM_SIZE = 40,
    parameter int W_BW     = 8
);
    logic [2:0]          layer_signal;
    logic [MEM_SIZE-1:0] fifo_dout;
    logic                empty;
    logic                fifo_ref;   // FIFO read enable ("ref" is a reserved word)
    logic [W_BW-1:0]     w_data;
    logic                w_valid;
    logic                w_ready;
    logic                w_last;
    logic                layer_done;
    logic                busy;

    modport master (
        input  layer_signal, fifo_dout, empty, w_ready,
        output fifo_ref, w_data, w_valid, w_last, layer_done, busy
    );

    modport slave (
        output layer_signal, fifo_dout, empty, w_ready,
        input  fifo_ref, w_data, w_valid, w_last, layer_done, busy
    );
endinterface

// File: rtl/fifo2core_unpack_lane_sel.sv
// Lane multiplexer: picks one W_BW-bit lane out of a packed MEM_SIZE-bit word, lane 0 = LSBs.
module fifo2core_unpack_lane_sel #(
    parameter int MEM_SIZE = 40,
    parameter int W_BW     = 8,
    parameter int SEL_W    = 3
) (
    input  logic [MEM_SIZE-1:0] word_i,
    input  logic [SEL_W-1:0]    sel_i,
    output logic [W_BW-1:0]     lane_o
);
    localparam int LANES = MEM_SIZE / W_BW;

    logic [W_BW-1:0] lanes [LANES];

    genvar gi;
    for (gi = 0; gi < LANES; gi++) begin : g_lane
        assign lanes[gi] = word_i[gi*W_BW +: W_BW];
    end

    // Compare-and-select keeps out-of-range selects at zero for non power-of-two lane counts.
    always_comb begin
        lane_o = '0;
        for (int i = 0; i < LANES; i++) begin
            if (sel_i == SEL_W'(i)) lane_o = lanes[i];
        end
    end
endmodule

// File: rtl/fifo2core_unpack.sv
// Pops packed weight words from the weight FIFO and streams their lanes to the compute core,
// one run per weight layer, with a layer_done pulse after the final weight is accepted.
module fifo2core_unpack
    import fifo2core_unpack_pkg::*;
#(
    parameter int MEM_SIZE = 40,
    parameter int W_BW     = 8,
    parameter int N_C1     = N_C1_DEF,
    parameter int N_C3     = N_C3_DEF,
    parameter int N_C5     = N_C5_DEF,
    parameter int N_FC     = N_FC_DEF,
    parameter int N_OL     = N_OL_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fifo2core_unpack_if.master   bus_if
);
    localparam int LANES  = MEM_SIZE / W_BW;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    state_e              state_q;
    logic [2:0]          layer_q;
    logic [WCNT_W-1:0]   word_cnt_q;
    logic [WCNT_W-1:0]   word_tgt_q;
    logic [WCNT_W-1:0]   word_tgt_d;
    logic [LANE_W-1:0]   lane_cnt_q;
    logic [MEM_SIZE-1:0] word_q;
    logic [W_BW-1:0]     lane_data;

    logic start, abort, hs, last_lane, last_word;

    always_comb begin
        word_tgt_d = '0;
        case (bus_if.layer_signal)
            L_C1:    word_tgt_d = WCNT_W'(N_C1);
            L_C3:    word_tgt_d = WCNT_W'(N_C3);
            L_C5:    word_tgt_d = WCNT_W'(N_C5);
            L_FC:    word_tgt_d = WCNT_W'(N_FC);
            L_OL:    word_tgt_d = WCNT_W'(N_OL);
            default: word_tgt_d = '0;
        endcase
    end

    // A run starts only on a change of code, so a held layer code never re-runs.
    assign start     = (state_q == ST_IDLE) && (bus_if.layer_signal != layer_q) &&
                       is_weight_layer(bus_if.layer_signal);
    assign abort     = (bus_if.layer_signal == L_IDLE);
    assign hs        = (state_q == ST_EMIT) && bus_if.w_ready;
    assign last_lane = (lane_cnt_q == LANE_W'(LANES - 1));
    assign last_word = (word_cnt_q == word_tgt_q - WCNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            layer_q    <= '0;
            word_cnt_q <= '0;
            word_tgt_q <= '0;
            lane_cnt_q <= '0;
            word_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    layer_q <= bus_if.layer_signal;
                    if (start) begin
                        word_tgt_q <= word_tgt_d;
                        word_cnt_q <= '0;
                        state_q    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (abort)              state_q <= ST_IDLE;
                    else if (!bus_if.empty) state_q <= ST_RDWAIT;
                end
                ST_RDWAIT: begin
                    // The popped word is discarded on abort; it was already read out of the FIFO.
                    if (abort) begin
                        word_q  <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        word_q     <= bus_if.fifo_dout;
                        lane_cnt_q <= '0;
                        state_q    <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (abort) begin
                        word_q  <= '0;
                        state_q <= ST_IDLE;
                    end else if (hs) begin
                        if (last_lane) begin
                            lane_cnt_q <= '0;
                            word_cnt_q <= word_cnt_q + WCNT_W'(1);
                            state_q    <= last_word ? ST_DONE : ST_FETCH;
                        end else begin
                            lane_cnt_q <= lane_cnt_q + LANE_W'(1);
                        end
                    end
                end
                ST_DONE:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    fifo2core_unpack_lane_sel #(
        .MEM_SIZE (MEM_SIZE),
        .W_BW     (W_BW),
        .SEL_W    (LANE_W)
    ) u_lane_sel (
        .word_i   (word_q),
        .sel_i    (lane_cnt_q),
        .lane_o   (lane_data)
    );

    assign bus_if.fifo_ref   = (state_q == ST_FETCH) && !bus_if.empty;
    assign bus_if.w_valid    = (state_q == ST_EMIT);
    assign bus_if.w_data     = (state_q == ST_EMIT) ? lane_data : '0;
    assign bus_if.w_last     = (state_q == ST_EMIT) && last_lane && last_word;
    assign bus_if.layer_done = (state_q == ST_DONE);
    assign bus_if.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo2core_unpack.sv
// Self-checking bench: FIFO model, random core back-pressure, and a queue-based model of the
// expected weight stream (every pushed word contributes its lanes LSB-first).
module tb_fifo2core_unpack;
    import fifo2core_unpack_pkg::*;

    localparam int MEM   = 40;
    localparam int WB    = 8;
    localparam int LANES = MEM / WB;

    typedef struct {
        logic [2:0] code;
        int         nw;
        int         mode;      // 0 ready=1, 1 toggle, 2 random, 3 ready=0
        int         gap;       // 0 preload all words, >0 push one word every gap cycles
        int         exp_refs;
        int         exp_wts;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo2core_unpack_if #(.MEM_SIZE(MEM), .W_BW(WB)) bus();

    fifo2core_unpack #(.MEM_SIZE(MEM), .W_BW(WB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [MEM-1:0] fifo_q [$];
    logic [WB-1:0]  exp_w  [$];
    int ref_cnt = 0, acc_cnt = 0, done_cnt = 0, cyc = 0, last_hs_cyc = -10;
    int ref_base = 0, acc_base = 0, run_len = 0;
    int rdy_mode = 3;
    bit chk_stable = 1'b1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [MEM-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[MEM-1:0];
    endfunction

    task automatic push_word(input logic [MEM-1:0] w);
        fifo_q.push_back(w);
        for (int l = 0; l < LANES; l++) exp_w.push_back(w[l*WB +: WB]);
    endtask

    task automatic begin_run(input int nw);
        acc_base = acc_cnt;
        ref_base = ref_cnt;
        run_len  = nw * LANES;
    endtask

    task automatic wait_done(input int d0, input string name);
        int c;
        c = 0;
        while (done_cnt == d0 && c < 4000) begin
            @(negedge clk);
            c++;
        end
        check({name, "_done_seen"}, done_cnt != d0, 1);
    endtask

    task automatic run_layer(input vec_t v);
        int d0;
        d0 = done_cnt;
        begin_run(v.nw);
        rdy_mode = v.mode;
        if (v.gap == 0) for (int i = 0; i < v.nw; i++) push_word(rand_word());
        repeat (2) @(posedge clk);
        #1 bus.layer_signal = v.code;
        if (v.gap > 0) begin
            for (int i = 0; i < v.nw; i++) begin
                repeat (v.gap) @(posedge clk);
                #1 push_word(rand_word());
            end
        end
        wait_done(d0, v.name);
        repeat (3) @(negedge clk);
        check({v.name, "_refs"},    ref_cnt - ref_base, v.exp_refs);
        check({v.name, "_weights"}, acc_cnt - acc_base, v.exp_wts);
        check({v.name, "_done_n"},  done_cnt - d0, 1);
        check({v.name, "_leftover"}, exp_w.size(), 0);
        check({v.name, "_idle"},    bus.busy, 0);
        $display("run %s: refs=%0d weights=%0d", v.name, ref_cnt - ref_base, acc_cnt - acc_base);
    endtask

    // FIFO model: one-cycle read latency, empty flag updated on the clock.
    initial begin
        bus.empty     = 1'b1;
        bus.fifo_dout = '0;
        forever begin
            @(posedge clk);
            if (rst_n && bus.fifo_ref) begin
                check("fifo_underflow", fifo_q.size() == 0, 0);
                if (fifo_q.size() != 0) begin
                    bus.fifo_dout <= fifo_q.pop_front();
                    ref_cnt++;
                end
            end
            bus.empty <= (fifo_q.size() == 0);
        end
    end

    initial begin
        bus.w_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.w_ready = 1'b1;
                1:       bus.w_ready = ~bus.w_ready;
                2:       bus.w_ready = 1'($urandom_range(0, 1));
                default: bus.w_ready = 1'b0;
            endcase
        end
    end

    // Stream monitor: sampled on the falling edge, handshakes take effect on the next rising edge.
    initial begin
        logic           prev_stall;
        logic [WB-1:0]  prev_data;
        logic           prev_last;
        logic [WB-1:0]  e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (bus.fifo_ref) check("ref_while_empty", bus.empty, 0);
            if (chk_stable && prev_stall) begin
                check("stall_valid", bus.w_valid, 1);
                check("stall_data",  bus.w_data, prev_data);
                check("stall_last",  bus.w_last, prev_last);
            end
            if (bus.w_valid)
                check("valid_without_word", (ref_cnt - ref_base) > ((acc_cnt - acc_base) / LANES), 1);
            if (bus.w_valid && bus.w_ready) begin
                check("weight_expected", exp_w.size() > 0, 1);
                if (exp_w.size() > 0) begin
                    e = exp_w.pop_front();
                    check("w_data", bus.w_data, e);
                end
                check("w_last", bus.w_last, (acc_cnt - acc_base) == run_len - 1);
                acc_cnt++;
                last_hs_cyc = cyc;
            end
            if (bus.layer_done) begin
                check("done_timing", cyc, last_hs_cyc + 1);
                done_cnt++;
            end
            prev_stall = bus.w_valid && !bus.w_ready;
            prev_data  = bus.w_data;
            prev_last  = bus.w_last;
        end
    end

    vec_t tbl [6];
    vec_t v;

    initial begin
        int d0;
        int c;
        tbl[0] = '{L_C3, 4,  1, 0,  4,  20,  "c3_toggle"};
        tbl[1] = '{L_C5, 24, 0, 10, 24, 120, "c5_trickle"};
        tbl[2] = '{L_FC, 17, 2, 0,  17, 85,  "fc_random"};
        tbl[3] = '{L_C1, 2,  2, 0,  2,  10,  "c1_random"};
        tbl[4] = '{L_C3, 4,  2, 5,  4,  20,  "c3_gap"};
        tbl[5] = '{L_OL, 2,  2, 3,  2,  10,  "ol_first"};

        rst_n = 1'b0;
        bus.layer_signal = L_IDLE;
        repeat (3) @(negedge clk);
        check("rst_busy",    bus.busy, 0);
        check("rst_valid",   bus.w_valid, 0);
        check("rst_ref",     bus.fifo_ref, 0);
        check("rst_done",    bus.layer_done, 0);
        check("rst_last",    bus.w_last, 0);
        check("rst_data",    bus.w_data, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // C1 with two known words and the core always ready: checks start latency too.
        rdy_mode = 0;
        d0 = done_cnt;
        begin_run(2);
        push_word(40'h05_04_03_02_01);
        push_word(40'h0A_09_08_07_06);
        repeat (2) @(posedge clk);
        #1 bus.layer_signal = L_C1;
        @(negedge clk);
        @(negedge clk);
        check("c1_first_ref", bus.fifo_ref, 1);
        @(negedge clk);
        check("c1_lat_valid_lo", bus.w_valid, 0);
        @(negedge clk);
        check("c1_lat_valid_hi", bus.w_valid, 1);
        check("c1_first_data", bus.w_data, 8'h01);
        wait_done(d0, "c1_fixed");
        repeat (3) @(negedge clk);
        check("c1_refs",    ref_cnt - ref_base, 2);
        check("c1_weights", acc_cnt - acc_base, 10);
        check("c1_done_n",  done_cnt - d0, 1);
        $display("run c1_fixed: refs=%0d weights=%0d", ref_cnt - ref_base, acc_cnt - acc_base);

        for (int i = 0; i < 6; i++) run_layer(tbl[i]);

        // OL held after its run: no restart until the code changes and comes back.
        c = ref_cnt;
        d0 = done_cnt;
        repeat (30) @(negedge clk);
        check("ol_hold_busy", bus.busy, 0);
        check("ol_hold_refs", ref_cnt - c, 0);
        check("ol_hold_done", done_cnt - d0, 0);
        $display("hold OL: refs=%0d done=%0d", ref_cnt - c, done_cnt - d0);
        @(posedge clk);
        #1 bus.layer_signal = L_S4;
        repeat (3) @(posedge clk);
        v = '{L_OL, 2, 0, 0, 2, 10, "ol_rerun"};
        run_layer(v);

        // Abort in the middle of FC word 5, then a full restart from word 0.
        rdy_mode = 0;
        d0 = done_cnt;
        begin_run(17);
        for (int i = 0; i < 17; i++) push_word(rand_word());
        repeat (2) @(posedge clk);
        #1 bus.layer_signal = L_FC;
        c = 0;
        while ((acc_cnt - acc_base) < 27 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check("abort_reached", (acc_cnt - acc_base) >= 27, 1);
        chk_stable = 1'b0;
        rdy_mode = 3;
        @(posedge clk);
        #2;
        check("abort_pre_valid", bus.w_valid, 1);
        bus.layer_signal = L_IDLE;
        @(negedge clk);
        @(negedge clk);
        check("abort_valid", bus.w_valid, 0);
        check("abort_busy",  bus.busy, 0);
        repeat (5) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_refs",    ref_cnt - ref_base, 6);
        $display("abort FC: refs=%0d done=%0d", ref_cnt - ref_base, done_cnt - d0);
        fifo_q.delete();
        exp_w.delete();
        repeat (3) @(negedge clk);
        chk_stable = 1'b1;
        v = '{L_FC, 17, 2, 0, 17, 85, "fc_restart"};
        run_layer(v);

        // Asynchronous reset in the middle of C3.
        rdy_mode = 2;
        begin_run(4);
        for (int i = 0; i < 4; i++) push_word(rand_word());
        repeat (2) @(posedge clk);
        #1 bus.layer_signal = L_C3;
        c = 0;
        while ((acc_cnt - acc_base) < 7 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check("rstmid_reached", (acc_cnt - acc_base) >= 7, 1);
        chk_stable = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_valid", bus.w_valid, 0);
        check("rstmid_data",  bus.w_data, 0);
        check("rstmid_last",  bus.w_last, 0);
        check("rstmid_ref",   bus.fifo_ref, 0);
        check("rstmid_done",  bus.layer_done, 0);
        check("rstmid_busy",  bus.busy, 0);
        $display("reset mid C3: busy=%0b valid=%0b", bus.busy, bus.w_valid);
        bus.layer_signal = L_IDLE;
        fifo_q.delete();
        exp_w.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rstmid_idle_after", bus.busy, 0);
        chk_stable = 1'b1;
        v = '{L_C1, 2, 2, 0, 2, 10, "c1_after_reset"};
        run_layer(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
